ofdm_rx_sample_buf: RTL and testbench
=====================================

OFDM_RX_SAMPLE_BUF -- requirements
Module: ofdm_rx_sample_buf

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16: width of each I and Q sample.
REQ-002 SHALL have parameter DEPTH_LOG2, default 11: buffer depth is 2**DEPTH_LOG2 complex samples.
REQ-003 SHALL have parameter START_THRESH, default 64: fill level required before reads are served; legal range 1..2**DEPTH_LOG2.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-005 SHALL have port i_clk, input, 1: single clock for all logic.
REQ-006 SHALL have port i_reset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port i_valid, input, 1: write strobe for in_data_i/in_data_q.
REQ-008 SHALL have ports in_data_i and in_data_q, input, DATA_SIZE each: sample written.
REQ-009 SHALL have port i_rd_en, input, 1: read request from the frame receiver (its wait-data flag).
REQ-010 SHALL have port o_valid, input-to-output latency 1, output, 1: o_data_i/o_data_q hold a served sample.
REQ-011 SHALL have ports o_data_i and o_data_q, output, DATA_SIZE each: sample read.
REQ-012 SHALL have port o_level, output, DEPTH_LOG2+1: current number of stored samples.
REQ-013 SHALL have ports o_full and o_empty, output, 1 each: level == 2**DEPTH_LOG2 / level == 0.
REQ-014 SHALL have port o_streaming, output, 1: high in STREAM state.
REQ-015 SHALL have ports o_overflow and o_underflow, output, 1 each: sticky error flags.

Function
REQ-016 SHALL implement a circular buffer with write and read pointers of DEPTH_LOG2 bits wrapping modulo depth and a separate level counter.
REQ-017 SHALL accept a write when i_valid=1 and (not full, or a read is accepted in the same cycle).
REQ-018 SHALL drop a write when i_valid=1, full and no read accepted; drop sets o_overflow; stored data unchanged.
REQ-019 SHALL have states PRIME and STREAM; PRIME after reset.
REQ-020 In PRIME SHALL ignore i_rd_en (no read, o_valid=0, no underflow); PRIME -> STREAM when level >= START_THRESH at a clock edge.
REQ-021 In STREAM SHALL accept a read when i_rd_en=1 and level > 0; o_valid=1 and data presented exactly one cycle later; otherwise o_valid=0 that next cycle.
REQ-022 In STREAM, i_rd_en=1 with level == 0 SHALL set o_underflow and transition to PRIME in the same cycle.
REQ-023 Simultaneous accepted write and read SHALL leave level unchanged, including at full and at level 1.
REQ-024 o_data_i/o_data_q SHALL hold their last value when o_valid=0.
REQ-025 Sample order out SHALL equal accepted order in; I and Q of one sample are never separated.

Reset
REQ-026 i_reset=1 at a clock edge SHALL clear pointers, level, o_valid, o_data_i, o_data_q, o_overflow, o_underflow, counters to 0 and state to PRIME, regardless of ongoing traffic.
REQ-027 During reset writes and reads SHALL be ignored; o_empty=1, o_full=0, o_streaming=0.
REQ-028 Stored memory contents need not be cleared.

Configuration
REQ-029 Macro OFDM_RX_BUF_STATS_EN, when defined, SHALL add outputs o_drop_cnt and o_underrun_cnt (CNT_WIDTH each) counting dropped writes and underflow events, saturating at all-ones, cleared by reset.
REQ-030 Without OFDM_RX_BUF_STATS_EN these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, then 63 writes with i_rd_en=1 -> o_valid stays 0, o_streaming=0, o_level=63; 64th write -> o_streaming=1 next cycle.
REQ-032 Write ramp 0..99 (I=n, Q=~n), then hold i_rd_en=1 -> 100 outputs in order, each one cycle after request; then underflow=1, state PRIME.
REQ-033 DEPTH_LOG2=4: write 20 samples without reads -> o_full=1, o_level=16, o_overflow=1, o_drop_cnt=4 (STATS_EN); outputs 0..15.
REQ-034 At full, simultaneous write and read for 10 cycles -> o_level stays 16, no drops, order preserved across pointer wrap.
REQ-035 i_reset pulsed mid-stream with level 40 -> next cycle o_level=0, o_valid=0, flags cleared, state PRIME.
REQ-036 Build without OFDM_RX_BUF_STATS_EN -> REQ-031..035 pass excluding counter checks; counter ports absent.

Source files
------------

// File: rtl/ofdm_rx_sample_buf.sv
// Elastic I/Q sample buffer between the OFDM front end and the frame receiver.
// Optional statistics counters are built when OFDM_RX_BUF_STATS_EN is defined.
//
// state  | meaning
// -------+-------------------------------------------------------------
// PRIME  | filling; read requests ignored until level >= START_THRESH
// STREAM | serving reads; a read on an empty buffer falls back to PRIME
module ofdm_rx_sample_buf #(
   parameter int DATA_SIZE    = 16,
   parameter int DEPTH_LOG2   = 11,
   parameter int START_THRESH = 64,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_valid,
   input  logic [DATA_SIZE-1:0]  in_data_i,
   input  logic [DATA_SIZE-1:0]  in_data_q,
   input  logic                  i_rd_en,
   output logic                  o_valid,
   output logic [DATA_SIZE-1:0]  o_data_i,
   output logic [DATA_SIZE-1:0]  o_data_q,
   output logic [DEPTH_LOG2:0]   o_level,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_streaming,
   output logic                  o_overflow,
`ifdef OFDM_RX_BUF_STATS_EN
   output logic [CNT_WIDTH-1:0]  o_drop_cnt,
   output logic [CNT_WIDTH-1:0]  o_underrun_cnt,
`endif
   output logic                  o_underflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LEVEL_FULL   = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LEVEL_THRESH = (DEPTH_LOG2+1)'(START_THRESH);

   typedef enum logic {PRIME = 1'b0, STREAM = 1'b1} state_t;

   state_t                   state;
   logic [DEPTH_LOG2-1:0]    wr_ptr;
   logic [DEPTH_LOG2-1:0]    rd_ptr;
   logic [DEPTH_LOG2:0]      level;
   logic [2*DATA_SIZE-1:0]   mem [DEPTH];

   logic rd_acc;
   logic rd_starved;
   logic wr_acc;
   logic wr_drop;

   assign rd_acc     = (state == STREAM) && i_rd_en && (level != '0);
   assign rd_starved = (state == STREAM) && i_rd_en && (level == '0);
   // a same-cycle read frees the slot, so a write at full still lands
   assign wr_acc     = i_valid && ((level != LEVEL_FULL) || rd_acc);
   assign wr_drop    = i_valid && (level == LEVEL_FULL) && !rd_acc;

   always_ff @(posedge i_clk) begin
      if (!i_reset && wr_acc)
         mem[wr_ptr] <= {in_data_i, in_data_q};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= PRIME;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         o_valid     <= 1'b0;
         o_data_i    <= '0;
         o_data_q    <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
         o_valid <= rd_acc;
         if (rd_acc)
            {o_data_i, o_data_q} <= mem[rd_ptr];
         if (wr_drop)
            o_overflow <= 1'b1;
         if (rd_starved)
            o_underflow <= 1'b1;
         case (state)
            PRIME:   if (level >= LEVEL_THRESH) state <= STREAM;
            STREAM:  if (rd_starved) state <= PRIME;
            default: state <= PRIME;
         endcase
      end
   end

`ifdef OFDM_RX_BUF_STATS_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_drop_cnt     <= '0;
         o_underrun_cnt <= '0;
      end else begin
         if (wr_drop && (o_drop_cnt != '1))
            o_drop_cnt <= o_drop_cnt + 1'b1;
         if (rd_starved && (o_underrun_cnt != '1))
            o_underrun_cnt <= o_underrun_cnt + 1'b1;
      end
   end
`endif

   // status is forced to its reset view while reset is held
   assign o_level     = level;
   assign o_full      = !i_reset && (level == LEVEL_FULL);
   assign o_empty     = i_reset || (level == '0);
   assign o_streaming = !i_reset && (state == STREAM);

endmodule

// File: tb/tb_ofdm_rx_sample_buf.sv
// Directed bench for ofdm_rx_sample_buf: a default-size instance and a 16-deep one.
module tb_ofdm_rx_sample_buf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // default instance
   logic        a_rst, a_vld, a_rd;
   logic [15:0] a_di, a_dq;
   logic        a_ov, a_full, a_empty, a_str, a_ovf, a_unf;
   logic [15:0] a_oi, a_oq;
   logic [11:0] a_lvl;
   // 16-deep instance
   logic        b_rst, b_vld, b_rd;
   logic [15:0] b_di, b_dq;
   logic        b_ov, b_full, b_empty, b_str, b_ovf, b_unf;
   logic [15:0] b_oi, b_oq;
   logic [4:0]  b_lvl;
`ifdef OFDM_RX_BUF_STATS_EN
   logic [15:0] a_drop, a_urun, b_drop, b_urun;
`endif

   ofdm_rx_sample_buf u_dut_a (
      .i_clk(clk), .i_reset(a_rst), .i_valid(a_vld), .in_data_i(a_di), .in_data_q(a_dq),
      .i_rd_en(a_rd), .o_valid(a_ov), .o_data_i(a_oi), .o_data_q(a_oq), .o_level(a_lvl),
      .o_full(a_full), .o_empty(a_empty), .o_streaming(a_str), .o_overflow(a_ovf),
`ifdef OFDM_RX_BUF_STATS_EN
      .o_drop_cnt(a_drop), .o_underrun_cnt(a_urun),
`endif
      .o_underflow(a_unf)
   );

   ofdm_rx_sample_buf #(.DEPTH_LOG2(4), .START_THRESH(16)) u_dut_b (
      .i_clk(clk), .i_reset(b_rst), .i_valid(b_vld), .in_data_i(b_di), .in_data_q(b_dq),
      .i_rd_en(b_rd), .o_valid(b_ov), .o_data_i(b_oi), .o_data_q(b_oq), .o_level(b_lvl),
      .o_full(b_full), .o_empty(b_empty), .o_streaming(b_str), .o_overflow(b_ovf),
`ifdef OFDM_RX_BUF_STATS_EN
      .o_drop_cnt(b_drop), .o_underrun_cnt(b_urun),
`endif
      .o_underflow(b_unf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] v;
      a_rst = 1'b1; a_vld = 1'b0; a_rd = 1'b0; a_di = '0; a_dq = '0;
      b_rst = 1'b1; b_vld = 1'b0; b_rd = 1'b0; b_di = '0; b_dq = '0;
      step();
      step();
      chk("rst_level",  32'(a_lvl), 0);
      chk("rst_empty",  32'(a_empty), 1);
      chk("rst_full",   32'(a_full), 0);
      chk("rst_stream", 32'(a_str), 0);
      chk("rst_valid",  32'(a_ov), 0);
      chk("rst_ovf",    32'(a_ovf), 0);
      chk("rst_unf",    32'(a_unf), 0);
      chk("rst_b_empty", 32'(b_empty), 1);
      a_rst = 1'b0;
      b_rst = 1'b0;

      // priming: reads requested but ignored
      a_rd = 1'b1;
      for (int n = 0; n < 63; n++) begin
         v = 16'(n);
         a_vld = 1'b1; a_di = v; a_dq = ~v;
         step();
         chk("prime_no_valid", 32'(a_ov), 0);
      end
      chk("prime_level63",  32'(a_lvl), 63);
      chk("prime_stream63", 32'(a_str), 0);
      chk("prime_no_unf",   32'(a_unf), 0);
      a_rd = 1'b0;
      v = 16'd63; a_di = v; a_dq = ~v;
      step();
      a_vld = 1'b0;
      step();
      chk("stream_at64", 32'(a_str), 1);
      chk("level64",     32'(a_lvl), 64);
      for (int n = 64; n < 100; n++) begin
         v = 16'(n);
         a_vld = 1'b1; a_di = v; a_dq = ~v;
         step();
      end
      a_vld = 1'b0;
      chk("level100", 32'(a_lvl), 100);

      // drain ramp in order, one cycle per request
      a_rd = 1'b1;
      for (int k = 0; k < 100; k++) begin
         v = 16'(k);
         step();
         chk("ramp_valid", 32'(a_ov), 1);
         chk("ramp_i", 32'(a_oi), 32'(v));
         chk("ramp_q", 32'(a_oq), 32'(16'(~v)));
      end
      chk("drained_level", 32'(a_lvl), 0);
      chk("drained_empty", 32'(a_empty), 1);
      step();
      chk("starve_valid",  32'(a_ov), 0);
      chk("starve_unf",    32'(a_unf), 1);
      chk("starve_prime",  32'(a_str), 0);
      chk("starve_hold_i", 32'(a_oi), 99);
      chk("starve_hold_q", 32'(a_oq), 32'(16'(~16'd99)));
`ifdef OFDM_RX_BUF_STATS_EN
      chk("starve_urun_cnt", 32'(a_urun), 1);
      chk("starve_drop_cnt", 32'(a_drop), 0);
`endif
      a_rd = 1'b0;

      // reset mid-stream with 40 stored
      for (int n = 0; n < 64; n++) begin
         v = 16'(200 + n);
         a_vld = 1'b1; a_di = v; a_dq = ~v;
         step();
      end
      a_vld = 1'b0;
      step();
      chk("restream", 32'(a_str), 1);
      a_rd = 1'b1;
      for (int k = 0; k < 24; k++) step();
      a_rd = 1'b0;
      chk("restream_last_i", 32'(a_oi), 223);
      chk("level40",         32'(a_lvl), 40);
      chk("unf_sticky",      32'(a_unf), 1);
      a_rst = 1'b1; a_vld = 1'b1; a_rd = 1'b1;
      step();
      chk("midrst_level",  32'(a_lvl), 0);
      chk("midrst_valid",  32'(a_ov), 0);
      chk("midrst_unf",    32'(a_unf), 0);
      chk("midrst_ovf",    32'(a_ovf), 0);
      chk("midrst_stream", 32'(a_str), 0);
      chk("midrst_data_i", 32'(a_oi), 0);
      chk("midrst_empty",  32'(a_empty), 1);
`ifdef OFDM_RX_BUF_STATS_EN
      chk("midrst_urun_cnt", 32'(a_urun), 0);
`endif
      a_rst = 1'b0; a_vld = 1'b0;
      step();
      chk("postrst_prime_valid", 32'(a_ov), 0);
      chk("postrst_level",       32'(a_lvl), 0);
      a_rd = 1'b0;

      // small buffer: overfill
      for (int n = 0; n < 20; n++) begin
         v = 16'(n);
         b_vld = 1'b1; b_di = v; b_dq = ~v;
         step();
      end
      chk("ovr_full",   32'(b_full), 1);
      chk("ovr_level",  32'(b_lvl), 16);
      chk("ovr_flag",   32'(b_ovf), 1);
      chk("ovr_stream", 32'(b_str), 1);
`ifdef OFDM_RX_BUF_STATS_EN
      chk("ovr_drop_cnt", 32'(b_drop), 4);
`endif

      // full: write and read together across the pointer wrap
      b_rd = 1'b1;
      for (int k = 0; k < 10; k++) begin
         v = 16'(100 + k);
         b_di = v; b_dq = ~v;
         step();
         chk("full_rw_valid", 32'(b_ov), 1);
         chk("full_rw_i",     32'(b_oi), 32'(k));
         chk("full_rw_level", 32'(b_lvl), 16);
      end
      b_vld = 1'b0;
      chk("full_rw_full", 32'(b_full), 1);
`ifdef OFDM_RX_BUF_STATS_EN
      chk("full_rw_drop_cnt", 32'(b_drop), 4);
`endif
      for (int k = 0; k < 16; k++) begin
         v = (k < 6) ? 16'(10 + k) : 16'(100 + k - 6);
         step();
         chk("tail_valid", 32'(b_ov), 1);
         chk("tail_i", 32'(b_oi), 32'(v));
         chk("tail_q", 32'(b_oq), 32'(16'(~v)));
      end
      chk("tail_empty", 32'(b_empty), 1);
      step();
      chk("b_starve_unf",   32'(b_unf), 1);
      chk("b_starve_valid", 32'(b_ov), 0);
`ifdef OFDM_RX_BUF_STATS_EN
      chk("b_starve_urun_cnt", 32'(b_urun), 1);
`endif
      b_rd = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
